// File: rtl/room_cmd_pkg.sv
// Shared types and defaults for the player command front end.
package room_cmd_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned NUM_DIRS            = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_HOLDOFF_CYCLES  = 2;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability counter and a one-cycle pulse
// on every accepted rising level. Releases produce no pulse.
module btn_debounce
    import room_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d, level_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/room_cmd_encoder.sv
// Player-side front end: turns four raw buttons into single move strobes,
// rejecting simultaneous presses, spacing moves apart and counting them.
module room_cmd_encoder
    import room_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_n,
    input  logic               btn_s,
    input  logic               btn_e,
    input  logic               btn_w,
    input  logic               lock,
    output logic               n,
    output logic               s,
    output logic               e,
    output logic               w,
    output logic               err_multi,
    output logic               busy,
    output logic [COUNT_W-1:0] move_count
);

    localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    // Reset asserts asynchronously but leaves on a clock edge.
    logic rst_meta_q, rst_sync_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic [NUM_DIRS-1:0] btn_raw;
    logic [NUM_DIRS-1:0] press;
    logic [2:0]          press_cnt;

    assign btn_raw[DIR_N] = btn_n;
    assign btn_raw[DIR_S] = btn_s;
    assign btn_raw[DIR_E] = btn_e;
    assign btn_raw[DIR_W] = btn_w;

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk    (clk),
            .rst_n  (rst_sync_q),
            .btn_i  (btn_raw[i]),
            .press_o(press[i])
        );
    end

    assign press_cnt = popcount4(press);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NUM_DIRS-1:0] strobe_q, strobe_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [COUNT_W-1:0]  count_q, count_d;

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // lock only gates the decision taken in IDLE; a started move always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!lock && press_cnt == 3'd1) state_d = FIRE;
            FIRE:    state_d = HOLD;
            HOLD:    if (hold_q == HOLD_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        strobe_d = '0;
        err_d    = 1'b0;
        busy_d   = (state_d != IDLE);
        hold_d   = hold_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (!lock) begin
                    if (press_cnt == 3'd1) begin
                        strobe_d = press;
                    end else if (press_cnt > 3'd1) begin
                        err_d = 1'b1;
                    end
                end
            end
            FIRE: begin
                hold_d = HOLD_W'(HOLDOFF_CYCLES);
                if (count_q != '1) count_d = count_q + COUNT_W'(1);
            end
            HOLD:    hold_d = hold_q - HOLD_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            hold_q   <= '0;
            strobe_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            hold_q   <= hold_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

    assign n          = strobe_q[DIR_N];
    assign s          = strobe_q[DIR_S];
    assign e          = strobe_q[DIR_E];
    assign w          = strobe_q[DIR_W];
    assign err_multi  = err_q;
    assign busy       = busy_q;
    assign move_count = count_q;

endmodule
